pm_noc_out_arb: RTL and testbench
=================================

# pm_noc_out_arb

Round-robin, packet-locked arbiter that shares the processing module's single outgoing NoC packet stream among up to four local requesters, e.g. the core-side DTU port and a debug/UART bridge. It sits inside the PM wrapper, upstream of the asynchronous NoC output FIFO write side. Multi-flit packets are never interleaved. Output is fully registered so the FIFO write interface sees clean timing.

## Interface
- NUM_REQ, 2: number of requesters; legal range 2..4.
- DATA_WIDTH, NOC_ASYNC_FIFO_PACKET_SIZE: flit width.
- clk_i  in  1  PM clock.
- reset_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  NUM_REQ  per-requester flit valid.
- req_data_i  in  NUM_REQ*DATA_WIDTH  per-requester flit; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last_i  in  NUM_REQ  flit is the last of its packet.
- req_ready_o  out  NUM_REQ  flit accepted this cycle when valid & ready.
- out_valid_o  out  1  registered flit valid toward the NoC FIFO.
- out_data_o  out  DATA_WIDTH  registered flit.
- out_last_o  out  1  registered last marker.
- out_ready_i  in  1  downstream accepts when valid & ready.
- grant_o  out  NUM_REQ  one-hot current owner; zero when idle.
- busy_o  out  1  high while in LOCKED.
- stat_clr_i, stat_cnt_o: present only with PM_NOC_ARB_STATS_EN (see Configuration).

## Operation
- FSM states: IDLE and LOCKED.
- IDLE behaviour:
  - If any req_valid_i is high, select the winner round-robin, searching from rr_ptr+1 upward modulo NUM_REQ.
  - Register the winner into grant_o and move to LOCKED.
  - If no req_valid_i is high, stay in IDLE.
- LOCKED behaviour:
  - req_ready_o[owner] = ~out_valid_o | out_ready_i.
  - All other req_ready_o bits are 0.
  - An accepted flit loads data and last into the output register and sets out_valid_o.
- Leaving LOCKED:
  - Acceptance of a flit with req_last_i = 1 returns the FSM to IDLE.
  - In the same cycle, rr_ptr becomes the owner index and grant_o clears.
- If the owner drops req_valid_i mid-packet, the lock holds indefinitely; there is no timeout.
- Output register behaviour:
  - out_valid_o clears on out_ready_i unless a new flit loads in the same cycle; simultaneous load and drain keeps it high.
  - out_data_o and out_last_o hold stable while out_valid_o & ~out_ready_i.
- The output register drains independently of the FSM. A last flit may still be pending downstream while IDLE arbitrates the next packet.
- Single-flit packet (valid & last on the first flit): LOCKED for exactly one accept.
- Reset values: state IDLE; rr_ptr = NUM_REQ-1, so requester 0 wins first; grant_o, req_ready_o and out_valid_o are 0; out_data_o and out_last_o are 0; busy_o is 0.
- Reset mid-packet: the partial packet is discarded and the output register is cleared. Upstream sources share the same reset.

## Timing
- Arbitration takes 1 cycle: valid seen in IDLE at cycle N gives grant at N+1 and the first ready at N+1.
- Flit latency: accepted at cycle N, visible on out_valid_o/out_data_o at N+1.
- Sustained throughput is 1 flit/cycle within a packet. There is 1 bubble cycle per packet boundary (the IDLE cycle).
- req_ready_o is combinational from registered state and out_ready_i. No other combinational input-to-output paths exist.

## Configuration
- Macro PM_NOC_ARB_STATS_EN.
- Defined:
  - Adds port stat_clr_i  in  1  and port stat_cnt_o  out  NUM_REQ*32.
  - stat_cnt_o holds one 32-bit flit counter per requester.
  - A counter increments on every flit accepted from its requester and saturates at 0xFFFF_FFFF.
  - stat_clr_i has priority over increment; counters reset to 0.
- Undefined: neither port nor any counter logic exists; arbitration behaviour is identical.

## Structure
- Package pm_noc_arb_pkg:
  - FSM state enum (IDLE, LOCKED).
  - STAT_WIDTH = 32.
  - MAX_REQ = 4.
  - Helper function converting one-hot to index.
- Sub-module pm_rr_pick: combinational round-robin picker.
  - Inputs: request vector and rr_ptr.
  - Outputs: one-hot winner and any_req.
  - Parameterised by NUM_REQ.

## Test plan
- Reset, then req0 sends a 3-flit packet with out_ready_i held 1 → grant_o = 0b01 from cycle 1; three flits appear on out at cycles 2..4 in order; out_last_o is set on the third; busy_o drops after the third accept.
- req0 and req1 both valid continuously with 2-flit packets → grants alternate 0,1,0,1; packets are never interleaved; one idle bubble between packets.
- req1 mid-packet while out_ready_i is held low for 5 cycles → out_data_o is stable; req_ready_o[1] = 0 while the output register is full; no flit is lost or duplicated.
- Owner drops req_valid_i for 4 cycles mid-packet while req0 is valid → grant stays with req1; req0 is served only after req1's last flit.
- Reset asserted during the second flit of a packet → next cycle out_valid_o = 0, grant_o = 0 and state IDLE; the next arbitration starts at requester 0.
- With PM_NOC_ARB_STATS_EN: req0 sends 10 flits and req1 sends 3 → stat_cnt_o reads 10 and 3; stat_clr_i asserted in the same cycle as an accept → the counter reads 0.

Source files
------------

// File: rtl/pm_noc_arb_pkg.sv
// Shared types, constants and helpers for the PM NoC output arbiter.
// Optional flit statistics are enabled with the PM_NOC_ARB_STATS_EN macro.
package pm_noc_arb_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   localparam int STAT_WIDTH = 32;
   localparam int MAX_REQ    = 4;
   localparam int PTR_WIDTH  = 2;
   localparam int NOC_ASYNC_FIFO_PACKET_SIZE = 32;

   // Index of the set bit in a one-hot vector; zero input maps to index 0.
   function automatic logic [PTR_WIDTH-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
      logic [PTR_WIDTH-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (oh[i]) idx = PTR_WIDTH'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/pm_rr_pick.sv
// Combinational round-robin picker: the first requester found searching
// upward from rr_ptr+1 (modulo NUM_REQ) wins.
module pm_rr_pick
   import pm_noc_arb_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0]   req,
   input  logic [PTR_WIDTH-1:0] rr_ptr,
   output logic [NUM_REQ-1:0]   winner,
   output logic                 any_req
);

   logic found;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j] && (j == (int'(rr_ptr) + 1 + k) % NUM_REQ)) begin
               winner[j] = 1'b1;
               found     = 1'b1;
            end
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/pm_noc_out_arb.sv
// Packet-locked round-robin arbiter feeding the PM's single NoC output stream.
// Define PM_NOC_ARB_STATS_EN to add per-requester accepted-flit counters.
module pm_noc_out_arb
   import pm_noc_arb_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = NOC_ASYNC_FIFO_PACKET_SIZE
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]            req_last_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   output logic                          out_valid_o,
   output logic [DATA_WIDTH-1:0]         out_data_o,
   output logic                          out_last_o,
   input  logic                          out_ready_i,
   output logic [NUM_REQ-1:0]            grant_o,
   output logic                          busy_o
`ifdef PM_NOC_ARB_STATS_EN
   ,
   input  logic                          stat_clr_i,
   output logic [NUM_REQ*STAT_WIDTH-1:0] stat_cnt_o
`endif
);

   // Handshake: a flit moves on any port in a cycle where valid and ready are
   // both high; ready never depends on valid of the same port.
   arb_state_t             state_q, state_d;
   logic [NUM_REQ-1:0]     grant_q, grant_d, winner, acc_vec;
   logic [PTR_WIDTH-1:0]   rr_ptr_q, rr_ptr_d, owner_idx;
   logic                   any_req, slot_free, accept, accept_last;
   logic [DATA_WIDTH-1:0]  owner_data;

   pm_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req     (req_valid_i),
      .rr_ptr  (rr_ptr_q),
      .winner  (winner),
      .any_req (any_req)
   );

   assign owner_idx   = onehot_to_idx(MAX_REQ'(grant_q));
   assign slot_free   = ~out_valid_o | out_ready_i;
   assign req_ready_o = ((state_q == LOCKED) && slot_free) ? grant_q : '0;
   assign acc_vec     = req_ready_o & req_valid_i;
   assign accept      = |acc_vec;
   assign accept_last = |(acc_vec & req_last_i);

   always_comb begin
      owner_data = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (grant_q[j]) owner_data = req_data_i[j*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= PTR_WIDTH'(NUM_REQ - 1);
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_d = winner;
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            // The lock is released only by the last flit; a stalled owner holds it.
            if (accept_last) begin
               state_d  = IDLE;
               grant_d  = '0;
               rr_ptr_d = owner_idx;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output register drains independently of the arbitration state.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
         out_last_o  <= 1'b0;
      end else if (accept) begin
         out_valid_o <= 1'b1;
         out_data_o  <= owner_data;
         out_last_o  <= accept_last;
      end else if (out_ready_i) begin
         out_valid_o <= 1'b0;
      end
   end

   assign grant_o = grant_q;
   assign busy_o  = (state_q == LOCKED);

`ifdef PM_NOC_ARB_STATS_EN
   logic [STAT_WIDTH-1:0] stat_q [NUM_REQ];

   always_ff @(posedge clk_i) begin
      for (int j = 0; j < NUM_REQ; j++) begin
         if (reset_i || stat_clr_i) begin
            stat_q[j] <= '0;
         end else if (acc_vec[j] && (stat_q[j] != '1)) begin
            stat_q[j] <= stat_q[j] + STAT_WIDTH'(1);
         end
      end
   end

   always_comb begin
      stat_cnt_o = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         stat_cnt_o[j*STAT_WIDTH +: STAT_WIDTH] = stat_q[j];
      end
   end
`endif

endmodule

// File: tb/tb_pm_noc_out_arb.sv
// Self-checking bench for pm_noc_out_arb: vector table, directed corner cases
// and randomized traffic against a cycle-level behavioural model.
module tb_pm_noc_out_arb;

   localparam int N  = 3;
   localparam int DW = 16;
   localparam int QD = 1024;

   typedef struct packed {
      logic          last;
      logic [DW-1:0] data;
   } flit_t;

   typedef struct packed {
      logic [N-1:0]  valid;
      logic [N-1:0]  last;
      logic [DW-1:0] d0;
      logic          ordy;
      logic [N-1:0]  grant;
      logic [N-1:0]  ready;
      logic          ov;
      logic [DW-1:0] od;
      logic          ol;
      logic          busy;
      logic          chk_d;
   } vec_t;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid, req_last, req_ready, grant;
   logic [N*DW-1:0] req_data;
   logic            out_valid, out_last, out_ready, busy;
   logic [DW-1:0]   out_data;
`ifdef PM_NOC_ARB_STATS_EN
   logic            stat_clr;
   logic [N*32-1:0] stat_cnt;
`endif

   always #5 clk = ~clk;

   pm_noc_out_arb #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .req_valid_i (req_valid),
      .req_data_i  (req_data),
      .req_last_i  (req_last),
      .req_ready_o (req_ready),
      .out_valid_o (out_valid),
      .out_data_o  (out_data),
      .out_last_o  (out_last),
      .out_ready_i (out_ready),
      .grant_o     (grant),
      .busy_o      (busy)
`ifdef PM_NOC_ARB_STATS_EN
      ,
      .stat_clr_i  (stat_clr),
      .stat_cnt_o  (stat_cnt)
`endif
   );

   int tests_run    = 0;
   int tests_failed = 0;

   // Sources: one circular flit buffer per requester.
   flit_t        src_mem [N][QD];
   int           src_head [N];
   int           src_tail [N];
   int           seq [N];
   logic [N-1:0] src_en;
   bit           src_mode;

   // Scoreboard and observation logs.
   logic [DW:0]  exp_q [$];
   int           grant_log [$];
   logic [N-1:0] prev_grant;
   int           idle_req_cycles, out_count;
   bit           model_on;

   // Behavioural model: owner index (-1 when free), last served requester, output slot.
   int            m_owner, m_prev;
   logic          m_ov, m_ol;
   logic [DW-1:0] m_od;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic bit_of(input logic [N-1:0] v, input int i);
      return 1'((v >> i) & N'(1));
   endfunction

   function automatic int pending();
      int s;
      s = exp_q.size();
      for (int i = 0; i < N; i++) s += src_tail[i] - src_head[i];
      return s;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_prev  = N - 1;
      m_ov    = 1'b0;
      m_ol    = 1'b0;
      m_od    = '0;
      exp_q.delete();
   endtask

   task automatic model_cycle();
      logic [N-1:0]  eg, er;
      logic          can, acc, l;
      logic [DW-1:0] d;
      logic [DW:0]   e;
      int            start_owner;
      bit            found;
      eg = '0;
      if (m_owner >= 0) eg = N'(1) << m_owner;
      can = !m_ov || out_ready;
      er  = (m_owner >= 0 && can) ? eg : '0;
      check("grant", grant, eg);
      check("req_ready", req_ready, er);
      check("busy", busy, m_owner >= 0);
      check("out_valid", out_valid, m_ov);
      if (m_ov) begin
         check("out_data", out_data, m_od);
         check("out_last", out_last, m_ol);
      end
      if (!reset && out_valid && out_ready) begin
         check("sb_nonempty", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_flit", {out_last, out_data}, e);
         end
      end
      if (reset) begin
         model_reset();
         return;
      end
      start_owner = m_owner;
      acc = (m_owner >= 0) && can && bit_of(req_valid, m_owner);
      if (acc) begin
         d = DW'(req_data >> (m_owner * DW));
         l = bit_of(req_last, m_owner);
         m_ov = 1'b1;
         m_od = d;
         m_ol = l;
         exp_q.push_back({l, d});
         if (l) begin
            m_prev  = m_owner;
            m_owner = -1;
         end
      end else if (out_ready) begin
         m_ov = 1'b0;
      end
      if (start_owner < 0) begin
         found = 0;
         for (int k = 1; k <= N; k++) begin
            if (!found && bit_of(req_valid, (m_prev + k) % N)) begin
               m_owner = (m_prev + k) % N;
               found   = 1;
            end
         end
      end
   endtask

   task automatic drive_srcs();
      flit_t f;
      for (int i = 0; i < N; i++) begin
         f = src_mem[i][src_head[i] % QD];
         req_valid[i] = src_en[i] && (src_tail[i] != src_head[i]);
         req_last[i]  = f.last;
         req_data[i*DW +: DW] = f.data;
      end
   endtask

   task automatic add_pkt(input int r, input int len);
      for (int f = 0; f < len; f++) begin
         src_mem[r][src_tail[r] % QD] = '{last: (f == len - 1), data: DW'(r * 4096 + (seq[r] % 4096))};
         seq[r]++;
         src_tail[r]++;
      end
   endtask

   task automatic tick();
      logic [N-1:0] acc;
      logic         rst;
      @(negedge clk);
      rst = reset;
      if (model_on) model_cycle();
      if (!rst && grant != '0 && prev_grant == '0) begin
         for (int i = 0; i < N; i++) if (grant[i]) grant_log.push_back(i);
      end
      if (!rst && !busy && (req_valid != '0)) idle_req_cycles++;
      if (!rst && out_valid && out_ready) out_count++;
      prev_grant = grant;
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (src_mode) begin
         for (int i = 0; i < N; i++) begin
            if (acc[i]) src_head[i]++;
            if (rst) src_head[i] = src_tail[i];
         end
         drive_srcs();
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      src_en = '0;
      out_ready = 1'b1;
      if (src_mode) drive_srcs();
      else begin
         req_valid = '0;
         req_last  = '0;
         req_data  = '0;
      end
      tick();
      tick();
      reset = 1'b0;
      grant_log.delete();
      idle_req_cycles = 0;
      out_count = 0;
   endtask

   task automatic drain(input string name, input int budget);
      src_en = '1;
      out_ready = 1'b1;
      drive_srcs();
      for (int c = 0; c < budget && pending() != 0; c++) tick();
      check(name, pending(), 0);
   endtask

   vec_t vecs [6];

   initial begin
      int start1;
      flit_t f1;

      vecs[0] = '{valid: 3'b001, last: 3'b000, d0: 16'h00A0, ordy: 1'b1, grant: 3'b000, ready: 3'b000,
                  ov: 1'b0, od: 16'h0000, ol: 1'b0, busy: 1'b0, chk_d: 1'b1};
      vecs[1] = '{valid: 3'b001, last: 3'b000, d0: 16'h00A0, ordy: 1'b1, grant: 3'b001, ready: 3'b001,
                  ov: 1'b0, od: 16'h0000, ol: 1'b0, busy: 1'b1, chk_d: 1'b0};
      vecs[2] = '{valid: 3'b001, last: 3'b000, d0: 16'h00A1, ordy: 1'b1, grant: 3'b001, ready: 3'b001,
                  ov: 1'b1, od: 16'h00A0, ol: 1'b0, busy: 1'b1, chk_d: 1'b1};
      vecs[3] = '{valid: 3'b001, last: 3'b001, d0: 16'h00A2, ordy: 1'b1, grant: 3'b001, ready: 3'b001,
                  ov: 1'b1, od: 16'h00A1, ol: 1'b0, busy: 1'b1, chk_d: 1'b1};
      vecs[4] = '{valid: 3'b000, last: 3'b000, d0: 16'h0000, ordy: 1'b1, grant: 3'b000, ready: 3'b000,
                  ov: 1'b1, od: 16'h00A2, ol: 1'b1, busy: 1'b0, chk_d: 1'b1};
      vecs[5] = '{valid: 3'b000, last: 3'b000, d0: 16'h0000, ordy: 1'b1, grant: 3'b000, ready: 3'b000,
                  ov: 1'b0, od: 16'h0000, ol: 1'b0, busy: 1'b0, chk_d: 1'b0};

      for (int i = 0; i < N; i++) begin
         src_head[i] = 0;
         src_tail[i] = 0;
         seq[i] = 0;
      end
      prev_grant = '0;
      src_mode = 0;
      model_on = 0;
`ifdef PM_NOC_ARB_STATS_EN
      stat_clr = 1'b0;
`endif
      do_reset();
      model_reset();
      model_on = 1;

      // 3-flit packet from requester 0, vector table.
      for (int i = 0; i < 6; i++) begin
         req_valid = vecs[i].valid;
         req_last  = vecs[i].last;
         req_data  = '0;
         req_data[DW-1:0] = vecs[i].d0;
         out_ready = vecs[i].ordy;
         #2;
         check("tbl_grant", grant, vecs[i].grant);
         check("tbl_ready", req_ready, vecs[i].ready);
         check("tbl_out_valid", out_valid, vecs[i].ov);
         check("tbl_busy", busy, vecs[i].busy);
         if (vecs[i].chk_d) begin
            check("tbl_out_data", out_data, vecs[i].od);
            check("tbl_out_last", out_last, vecs[i].ol);
         end
         tick();
      end

      // Two requesters with back-to-back 2-flit packets: strict alternation.
      src_mode = 1;
      do_reset();
      for (int p = 0; p < 3; p++) begin
         add_pkt(0, 2);
         add_pkt(1, 2);
      end
      src_en = 3'b011;
      drive_srcs();
      for (int c = 0; c < 100 && pending() != 0; c++) tick();
      check("rr_done", pending(), 0);
      check("rr_grant_count", grant_log.size(), 6);
      for (int p = 0; p < 6 && p < grant_log.size(); p++) check("rr_grant_order", grant_log[p], p % 2);
      check("rr_bubbles", idle_req_cycles, 6);

      // Backpressure mid-packet on requester 1.
      do_reset();
      start1 = src_tail[1];
      add_pkt(1, 4);
      f1 = src_mem[1][(start1 + 1) % QD];
      src_en = 3'b010;
      drive_srcs();
      tick();
      tick();
      tick();
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #2;
         check("bp_out_valid", out_valid, 1);
         check("bp_out_data", out_data, f1.data);
         check("bp_ready1", req_ready[1], 0);
         tick();
      end
      drain("bp_drain", 50);
      check("bp_flit_count", out_count, 4);

      // Owner stalls mid-packet while requester 0 waits.
      do_reset();
      add_pkt(1, 4);
      add_pkt(0, 2);
      src_en = 3'b010;
      drive_srcs();
      tick();
      tick();
      src_en = 3'b001;
      drive_srcs();
      for (int c = 0; c < 4; c++) begin
         #2;
         check("stall_grant", grant, 3'b010);
         tick();
      end
      drain("stall_drain", 50);
      check("stall_grant_count", grant_log.size(), 2);
      if (grant_log.size() == 2) begin
         check("stall_first", grant_log[0], 1);
         check("stall_second", grant_log[1], 0);
      end

      // Reset during the second flit of a packet.
      do_reset();
      add_pkt(0, 3);
      src_en = 3'b001;
      drive_srcs();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_grant", grant, 0);
      check("rst_busy", busy, 0);
      grant_log.delete();
      add_pkt(1, 1);
      add_pkt(0, 1);
      drain("rst_drain", 50);
      check("rst_grant_count", grant_log.size(), 2);
      if (grant_log.size() == 2) begin
         check("rst_first", grant_log[0], 0);
         check("rst_second", grant_log[1], 1);
      end

`ifdef PM_NOC_ARB_STATS_EN
      // Flit counters and clear-over-increment priority.
      do_reset();
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      add_pkt(0, 10);
      add_pkt(1, 3);
      drain("stat_drain", 100);
      check("stat_req0", stat_cnt[31:0], 10);
      check("stat_req1", stat_cnt[63:32], 3);
      add_pkt(0, 2);
      src_en = 3'b001;
      drive_srcs();
      tick();
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      #2;
      check("stat_clr_req0", stat_cnt[31:0], 0);
      check("stat_clr_req1", stat_cnt[63:32], 0);
      drain("stat_drain2", 50);
      check("stat_after_clr", stat_cnt[31:0], 1);
`endif

      // Randomized traffic: random packet lengths, source stalls and backpressure.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if ((src_tail[i] - src_head[i]) < 6 && $urandom_range(0, 3) == 0)
               add_pkt(i, $urandom_range(1, 5));
            src_en[i] = ($urandom_range(0, 9) < 8);
         end
         out_ready = ($urandom_range(0, 9) < 7);
         drive_srcs();
         tick();
      end
      drain("rand_drain", 500);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, tests_failed=%0d", tests_failed);
      $fatal(1, "watchdog");
   end

endmodule
